// File: rtl/compa_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// Holds the controller state encoding, the recorded result encoding and
// the mapping from a result to the three LED bits.
package compa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LT   = 2'd1,
        EQ   = 2'd2,
        GT   = 2'd3
    } result_t;

    // LED bit order is {lt, eq, gt}; NONE lights nothing.
    function automatic logic [2:0] result_to_leds(input result_t r);
        case (r)
            LT:      return 3'b100;
            EQ:      return 3'b010;
            GT:      return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/bit_compa_cell.sv
// Combinational single-bit magnitude compare.
// With sign_invert set, the bit is treated as a two's complement sign bit,
// so a 1 means "smaller" instead of "larger".
module bit_compa_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic sign_invert,
    output logic lt,
    output logic eq,
    output logic gt
);

    // Plain compare, with lt/gt swapped when the bit carries the sign.
    always_comb begin
        eq = (a_bit == b_bit);
        lt = 1'b0;
        gt = 1'b0;
        if (sign_invert) begin
            lt = a_bit & ~b_bit;
            gt = ~a_bit & b_bit;
        end else begin
            lt = ~a_bit & b_bit;
            gt = a_bit & ~b_bit;
        end
    end

endmodule

// File: rtl/n_bit_seq_compa.sv
// Bit-serial, MSB-first WIDTH-bit magnitude comparator with start/done
// handshake and registered LED outputs. Stops at the first differing bit.
// Optional macro SIGNED_COMPARE_EN: treat operands as two's complement by
// inverting the sense of the MSB comparison.
module n_bit_seq_compa
    import compa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bits_used,
    output logic                       led_A_lt_B,
    output logic                       led_A_eq_B,
    output logic                       led_A_gt_B
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    state_t         state;
    state_t         state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  cnt;
    result_t        result;
    logic [2:0]     leds;
    logic           done_r;
    logic [CW-1:0]  bits_used_r;
    logic           cell_lt;
    logic           cell_eq;
    logic           cell_gt;
    logic           sign_invert;

`ifdef SIGNED_COMPARE_EN
    assign sign_invert = (state == COMPARE) && (idx == MSB_IDX);
`else
    assign sign_invert = 1'b0;
`endif

    bit_compa_cell u_cell (
        .a_bit       (a_reg[idx]),
        .b_bit       (b_reg[idx]),
        .sign_invert (sign_invert),
        .lt          (cell_lt),
        .eq          (cell_eq),
        .gt          (cell_gt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: leave COMPARE at the first difference or after bit 0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COMPARE;
            COMPARE: if (!cell_eq || idx == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, bit walk and result recording.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            idx    <= '0;
            cnt    <= '0;
            result <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        idx    <= MSB_IDX;
                        cnt    <= '0;
                        result <= NONE;
                    end
                end
                COMPARE: begin
                    cnt <= cnt + CW'(1);
                    if (cell_gt)        result <= GT;
                    else if (cell_lt)   result <= LT;
                    else if (idx == '0) result <= EQ;
                    else                idx    <= idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Publish the recorded result on the DONE edge; hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r      <= 1'b0;
            leds        <= 3'b000;
            bits_used_r <= '0;
        end else begin
            done_r <= (state == DONE);
            if (state == DONE) begin
                leds        <= result_to_leds(result);
                bits_used_r <= cnt;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done       = done_r;
    assign bits_used  = bits_used_r;
    assign led_A_lt_B = leds[2];
    assign led_A_eq_B = leds[1];
    assign led_A_gt_B = leds[0];

endmodule

// File: tb/tb_n_bit_seq_compa.sv
// Self-checking bench for n_bit_seq_compa (WIDTH=8).
// Define SIGNED_COMPARE_EN for both RTL and bench to check the signed build.
module tb_n_bit_seq_compa;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy;
    logic             done;
    logic [CW-1:0]    bits_used;
    logic             led_A_lt_B;
    logic             led_A_eq_B;
    logic             led_A_gt_B;

    int compared = 0;
    int mismatched = 0;

    n_bit_seq_compa #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .bits_used  (bits_used),
        .led_A_lt_B (led_A_lt_B),
        .led_A_eq_B (led_A_eq_B),
        .led_A_gt_B (led_A_gt_B)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       leds;   // {lt, eq, gt}
        int               bits;
    } vec_t;

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: ordering from integer compare, length from the top differing bit.
    function automatic void refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     output logic [2:0] leds, output int bits);
        logic [WIDTH-1:0] diff;
        int pos;
        diff = a ^ b;
        pos = -1;
        for (int i = 0; i < WIDTH; i++) if (diff[i]) pos = i;
        bits = (pos < 0) ? WIDTH : WIDTH - pos;
`ifdef SIGNED_COMPARE_EN
        if ($signed(a) < $signed(b))      leds = 3'b100;
        else if ($signed(a) > $signed(b)) leds = 3'b001;
        else                              leds = 3'b010;
`else
        if (a < b)      leds = 3'b100;
        else if (a > b) leds = 3'b001;
        else            leds = 3'b010;
`endif
    endfunction

    // Start one comparison from a negedge and wait (bounded) for done.
    // Operands are scrambled right after capture.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output int lat, output int busy_n, output bit ok);
        int edges;
        A = a;
        B = b;
        start = 1'b1;
        edges = 0;
        busy_n = 0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            edges++;
            if (k == 0) begin
                start = 1'b0;
                A = WIDTH'($urandom);
                B = WIDTH'($urandom);
            end
            if (busy) busy_n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        lat = edges - 1;
    endtask

    task automatic runVector(input string name, input vec_t v);
        int lat, busy_n;
        bit ok;
        applyStimulus(v.a, v.b, lat, busy_n, ok);
        checkOutput({name, " done_seen"}, int'(ok), 1);
        checkOutput({name, " leds"}, int'({led_A_lt_B, led_A_eq_B, led_A_gt_B}), int'(v.leds));
        checkOutput({name, " bits_used"}, int'(bits_used), v.bits);
        checkOutput({name, " latency"}, lat, v.bits + 1);
        checkOutput({name, " busy_cycles"}, busy_n, v.bits + 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int dones;
        bit hold_ok;
        vec_t v;

        vecs[0] = '{8'h80, 8'h7F, 3'b001, 1};
`ifdef SIGNED_COMPARE_EN
        vecs[0].leds = 3'b100;
`endif
        vecs[1] = '{8'h5A, 8'h5A, 3'b010, 8};
        vecs[2] = '{8'h12, 8'h13, 3'b100, 8};
        vecs[3] = '{8'h00, 8'hFF, 3'b100, 1};
`ifdef SIGNED_COMPARE_EN
        vecs[3].leds = 3'b001;
`endif
        vecs[4] = '{8'h40, 8'h20, 3'b001, 2};
        vecs[5] = '{8'h0F, 8'h0E, 3'b001, 8};
        vecs[6] = '{8'hFF, 8'hFF, 3'b010, 8};
        vecs[7] = '{8'h3C, 8'h34, 3'b001, 5};

        doReset();
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset bits_used", int'(bits_used), 0);
        checkOutput("reset leds", int'({led_A_lt_B, led_A_eq_B, led_A_gt_B}), 0);

        for (int i = 0; i < 8; i++) runVector($sformatf("vec%0d", i), vecs[i]);

        // LEDs must hold through a long idle stretch.
        runVector("hold_setup", vecs[2]);
        hold_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ({led_A_lt_B, led_A_eq_B, led_A_gt_B} != 3'b100 || done || busy) hold_ok = 1'b0;
        end
        checkOutput("hold 20 idle", int'(hold_ok), 1);

        // Start held high through COMPARE and DONE must not queue a second run.
        A = 8'h00;
        B = 8'hFF;
        start = 1'b1;
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 2) begin
                start = 1'b0;
                checkOutput("ignore done_at_t+2", int'(done), 1);
                checkOutput("ignore leds", int'({led_A_lt_B, led_A_eq_B, led_A_gt_B}),
                            int'(vecs[3].leds));
            end
        end
        checkOutput("ignore done_count", dones, 1);

        // Reset in the middle of an equal-operand comparison.
        A = 8'h5A;
        B = 8'h5A;
        start = 1'b1;
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 0) start = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        checkOutput("midrst done_count", dones, 0);
        checkOutput("midrst busy", int'(busy), 0);
        checkOutput("midrst done", int'(done), 0);
        checkOutput("midrst bits_used", int'(bits_used), 0);
        checkOutput("midrst leds", int'({led_A_lt_B, led_A_eq_B, led_A_gt_B}), 0);
        rst = 1'b0;
        runVector("after_rst", vecs[4]);

        // Reset and start together: start is dropped.
        A = 8'h01;
        B = 8'h02;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checkOutput("rst_start activity", dones, 0);

        // Randomised back-to-back comparisons against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.a = WIDTH'($urandom);
            v.b = WIDTH'($urandom);
            if (i % 5 == 0) v.b = v.a ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
            if (i % 9 == 0) v.b = v.a;
            refModel(v.a, v.b, v.leds, v.bits);
            runVector($sformatf("rand%0d", i), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/n_bit_seq_compa.md
# n_bit_seq_compa

Parametrised, bit-serial, MSB-first magnitude comparator with a start/done handshake and registered LED result outputs. It extends the lab's single-bit comparator to WIDTH-bit operands. It compares one bit per clock and terminates early at the first differing bit. It sits between operand sources (switches or a test controller) and the board LEDs; results hold until the next comparison completes.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a comparison; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  one-cycle pulse when a result is written.
- bits_used  output  $clog2(WIDTH+1)  number of bit positions examined by the last comparison (1..WIDTH).
- led_A_lt_B  output  1  registered result: A < B.
- led_A_eq_B  output  1  registered result: A == B.
- led_A_gt_B  output  1  registered result: A > B.

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE: busy=0. On start=1:
  - latch A and B into a_reg and b_reg;
  - set idx=WIDTH-1 and cnt=0;
  - go to COMPARE.
- COMPARE: examine a_reg[idx] and b_reg[idx], and increment cnt.
  - Bits differ: record gt if a bit=1, lt otherwise. Go to DONE.
  - Bits equal and idx==0: record eq. Go to DONE.
  - Bits equal and idx>0: decrement idx and stay in COMPARE.
- DONE:
  - done=1 for this cycle only;
  - the LED outputs and bits_used are updated from the recorded result in the same cycle;
  - next state is IDLE.
- Exactly one LED is high after any completed comparison.
- All LEDs are 0 only between reset and the first completion.
- LEDs and bits_used hold their values until the next DONE.
- start is ignored while busy=1, including in the DONE cycle; it is not queued.
- Changes on A and B after capture have no effect on the comparison in progress.
- cnt saturates naturally at WIDTH, so no wrap-around is possible.

## Timing
- Reset values: busy=0, done=0, bits_used=0, all LEDs=0, state=IDLE.
- Latency: start is sampled at edge t.
  - COMPARE occupies edges t+1 .. t+n, where n = bits examined = WIDTH − (index of the first differing bit), or WIDTH if the operands are equal.
  - done and the updated outputs are visible after edge t+n+1.
  - Minimum latency is 2 cycles; maximum is WIDTH+1.
- Back-to-back: the earliest next accepted start is in the cycle after DONE, i.e. IDLE.
- rst mid-operation: returns to IDLE on the next edge with no done pulse. LEDs and bits_used return to 0.
- rst and start asserted together: rst wins and start is dropped.

## Configuration
- SIGNED_COMPARE_EN defined: operands are two's complement.
  - In the first COMPARE cycle (idx=WIDTH-1), if the sign bits differ, the operand with sign=1 is the smaller one: A's bit=1 records lt, B's bit=1 records gt.
  - All remaining bit positions compare as unsigned.
  - Latency is unchanged.
- Not defined: pure unsigned comparison at every bit position.

## Structure
- Package compa_pkg contains:
  - state enum typedef (IDLE, COMPARE, DONE);
  - a 2-bit result encoding typedef (NONE, LT, EQ, GT);
  - a function mapping the result encoding to the three LED bits.
- Sub-module bit_compa_cell: combinational 1-bit compare with a sign_invert input. It produces lt, eq and gt. The top level instantiates one cell and drives it from a_reg[idx] and b_reg[idx].

## Test plan
- WIDTH=8; A=8'h80, B=8'h7F, start at t:
  - unsigned: gt=1, done at t+2, bits_used=1;
  - with SIGNED_COMPARE_EN: lt=1.
- A=B=8'h5A: eq=1, done at t+9, bits_used=8, busy high for 9 cycles.
- A=8'h12, B=8'h13: lt=1, bits_used=8, done at t+9. LEDs remain at lt through 20 subsequent idle cycles.
- start pulsed at t+3 during the busy period of A=8'h00, B=8'hFF: no second comparison. Exactly one done, at t+2, with lt=1.
- rst asserted at t+4 during an equal-operand comparison:
  - no done pulse;
  - after the next edge, all outputs are 0 and busy=0;
  - a new start is accepted in the following cycle.
- Randomised back-to-back starts (A and B drawn with $random): each done result matches a reference model.
